// File: rtl/ram_dp_clr.sv
// Dual-port RAM: port A read/write with byte enables, port B read-only, both with
// registered 1-cycle reads. A clear sequencer zeroes every word after reset.
module ram_dp_clr #(
    parameter int DEPTH          = 1024,
    parameter int WORD_WIDTH     = 32,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter bit RDW_MODE       = 1'b0,
    localparam int AW            = $clog2(DEPTH),
    localparam int BE            = WORD_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_i,
    output logic                  busy_o,
    input  logic                  a_en_i,
    input  logic                  a_we_i,
    input  logic [BE-1:0]         a_be_i,
    input  logic [AW-1:0]         a_addr_i,
    input  logic [WORD_WIDTH-1:0] a_din_i,
    output logic [WORD_WIDTH-1:0] a_dout_o,
    output logic                  a_valid_o,
    input  logic                  b_en_i,
    input  logic [AW-1:0]         b_addr_i,
    output logic [WORD_WIDTH-1:0] b_dout_o,
    output logic                  b_valid_o
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state_q;
    logic [AW-1:0]           cnt_q;
    logic [WORD_WIDTH-1:0]   mem_q [DEPTH];
    logic [WORD_WIDTH-1:0]   a_dout_q;
    logic [WORD_WIDTH-1:0]   b_dout_q;
    logic                    a_valid_q;
    logic                    b_valid_q;
    logic                    a_wr_s;
    logic                    b_coll_s;
    logic [WORD_WIDTH-1:0]   b_next_d;

    function automatic logic [WORD_WIDTH-1:0] byte_merge(
        input logic [WORD_WIDTH-1:0] old_w,
        input logic [WORD_WIDTH-1:0] new_w,
        input logic [BE-1:0]         be
    );
        logic [WORD_WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < BE; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign a_wr_s   = a_en_i & a_we_i & (state_q == ST_READY) & ~rst_i;
    assign b_coll_s = a_wr_s & (a_addr_i == b_addr_i);

    // Port B next read value; write-first forwards the merged word on a collision
    always_comb begin
        b_next_d = mem_q[b_addr_i];
        if (!RDW_MODE && b_coll_s) begin
            b_next_d = byte_merge(mem_q[b_addr_i], a_din_i, a_be_i);
        end else begin
            b_next_d = mem_q[b_addr_i];
        end
    end

    // Array write port: clear sequencer has priority, otherwise per-lane A writes
    always_ff @(posedge clk) begin
        if (!rst_i && state_q == ST_CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (a_wr_s) begin
            for (int i = 0; i < BE; i++) begin
                if (a_be_i[i]) begin
                    mem_q[a_addr_i][8*i +: 8] <= a_din_i[8*i +: 8];
                end
            end
        end
    end

    // Clear/ready sequencer and registered read outputs
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            cnt_q     <= '0;
            a_dout_q  <= '0;
            b_dout_q  <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    a_valid_q <= 1'b0;
                    b_valid_q <= 1'b0;
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_q <= ST_READY;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_READY: begin
                    a_valid_q <= a_en_i & ~a_we_i;
                    b_valid_q <= b_en_i;
                    if (a_en_i && !a_we_i) begin
                        a_dout_q <= mem_q[a_addr_i];
                    end
                    if (b_en_i) begin
                        b_dout_q <= b_next_d;
                    end
                end
                default: begin
                    state_q   <= ST_CLEAR;
                    cnt_q     <= '0;
                    a_valid_q <= 1'b0;
                    b_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = (state_q == ST_CLEAR);
    assign a_dout_o  = a_dout_q;
    assign b_dout_o  = b_dout_q;
    assign a_valid_o = a_valid_q;
    assign b_valid_o = b_valid_q;

endmodule
